// File: rtl/viterbi_pkg.sv
// Constants and types shared between the radix-4 convolutional encoder and
// the Viterbi decoder control: code parameters, word width, FSM encodings.
package viterbi_pkg;

  localparam int K      = 3;
  localparam int CW_W   = 4;
  localparam int CNT_W  = 8;

  // Generator polynomials, MSB taps the current bit: G0 = 7 (octal), G1 = 5 (octal)
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENCODE = 2'd1,
    ST_TAIL   = 2'd2
  } enc_state_e;

  // Code pair {c0, c1} for one input bit u given the two previous bits.
  function automatic logic [1:0] conv_code(input logic u, input logic s1, input logic s0);
    logic [K-1:0] taps;
    taps = {u, s1, s0};
    return {^(taps & G0), ^(taps & G1)};
  endfunction

endpackage

// File: rtl/conv_enc_step.sv
// One radix-4 trellis step: encodes din[1] then din[0] and returns the
// 4-bit code word together with the shift state after both bits.
module conv_enc_step
  import viterbi_pkg::*;
(
  input  logic [1:0]      i_din,
  input  logic            i_s1,
  input  logic            i_s0,
  output logic [CW_W-1:0] o_code,
  output logic            o_ns1,
  output logic            o_ns0
);

  // Second bit sees the first bit as its most recent history.
  assign o_code = {conv_code(i_din[1], i_s1, i_s0), conv_code(i_din[0], i_din[1], i_s1)};
  assign o_ns1  = i_din[0];
  assign o_ns0  = i_din[1];

endmodule

// File: rtl/conv_encoder_r4.sv
// Rate-1/2 K=3 (7,5) convolutional encoder, two bits per clock, with a
// one-deep registered output slot and a zero-pair tail word per frame.
//
// state     | meaning
// ST_IDLE   | waiting for start; no data accepted
// ST_ENCODE | accepting FRAME_PAIRS input pairs
// ST_TAIL   | loading the 00 flush word, then waiting for it to be consumed
module conv_encoder_r4
  import viterbi_pkg::*;
#(
  parameter int FRAME_PAIRS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            start,
  input  logic [1:0]      din,
  input  logic            din_valid,
  output logic            din_ready,
  output logic [CW_W-1:0] dout,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic            dout_last,
  output logic            busy,
  output logic            frame_done
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_PAIRS - 1);

  enc_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_s1;
  logic             r_s0;
  logic [CW_W-1:0]  r_dout;
  logic             r_dout_valid;
  logic             r_dout_last;
  logic             r_frame_done;

  logic [CW_W-1:0]  w_data_code;
  logic             w_data_ns1;
  logic             w_data_ns0;
  logic [CW_W-1:0]  w_tail_code;
  logic             w_tail_ns1;
  logic             w_tail_ns0;
  logic             w_slot_free;
  logic             w_consume;
  logic             w_accept;

  conv_enc_step u_step_data (
    .i_din  (din),
    .i_s1   (r_s1),
    .i_s0   (r_s0),
    .o_code (w_data_code),
    .o_ns1  (w_data_ns1),
    .o_ns0  (w_data_ns0)
  );

  conv_enc_step u_step_tail (
    .i_din  (2'b00),
    .i_s1   (r_s1),
    .i_s0   (r_s0),
    .o_code (w_tail_code),
    .o_ns1  (w_tail_ns1),
    .o_ns0  (w_tail_ns0)
  );

  // The output slot can take a new word if empty or being drained this cycle.
  assign w_slot_free = !r_dout_valid || dout_ready;
  assign w_consume   = r_dout_valid && dout_ready;
  assign din_ready   = en && (r_state == ST_ENCODE) && w_slot_free;
  assign w_accept    = din_valid && din_ready;

  assign dout        = r_dout;
  assign dout_valid  = r_dout_valid;
  assign dout_last   = r_dout_last;
  assign busy        = (r_state != ST_IDLE);
  // Masked so a freeze that lands right after the last consume shows no pulse.
  assign frame_done  = r_frame_done && en;

  // Frame sequencing, shift state, pair counter and the output slot; en=0 freezes all.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_s1         <= 1'b0;
      r_s0         <= 1'b0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_dout_last  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (en) begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_state <= ST_ENCODE;
              r_cnt   <= '0;
              r_s1    <= 1'b0;
              r_s0    <= 1'b0;
            end
          end
          ST_ENCODE: begin
            if (w_accept) begin
              r_dout       <= w_data_code;
              r_dout_valid <= 1'b1;
              r_dout_last  <= 1'b0;
              r_s1         <= w_data_ns1;
              r_s0         <= w_data_ns0;
              r_cnt        <= r_cnt + CNT_W'(1);
              if (r_cnt == LAST_CNT) begin
                r_state <= ST_TAIL;
              end
            end else if (w_consume) begin
              r_dout_valid <= 1'b0;
            end
          end
          ST_TAIL: begin
            // dout_last doubles as the "tail word already loaded" flag.
            if (!r_dout_last) begin
              if (w_slot_free) begin
                r_dout       <= w_tail_code;
                r_dout_valid <= 1'b1;
                r_dout_last  <= 1'b1;
                r_s1         <= w_tail_ns1;
                r_s0         <= w_tail_ns0;
              end
            end else if (w_consume) begin
              r_dout_valid <= 1'b0;
              r_dout_last  <= 1'b0;
              r_frame_done <= 1'b1;
              r_state      <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_encoder_r4.sv
// Randomized frame-level bench for conv_encoder_r4 against a bit-serial
// 7/5 reference, plus a directed single-pair frame on a FRAME_PAIRS=1 copy.
module tb_conv_encoder_r4;

  localparam int FP = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       en = 1'b0, start = 1'b0, din_valid = 1'b0, dout_ready = 1'b0;
  logic [1:0] din = 2'b00;
  logic       din_ready, dout_valid, dout_last, busy, frame_done;
  logic [3:0] dout;

  logic       en1 = 1'b0, start1 = 1'b0, din_valid1 = 1'b0, dout_ready1 = 1'b0;
  logic [1:0] din1 = 2'b00;
  logic       din_ready1, dout_valid1, dout_last1, busy1, frame_done1;
  logic [3:0] dout1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  conv_encoder_r4 #(.FRAME_PAIRS(FP)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .busy(busy), .frame_done(frame_done)
  );

  conv_encoder_r4 #(.FRAME_PAIRS(1)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .start(start1), .din(din1), .din_valid(din_valid1),
    .din_ready(din_ready1), .dout(dout1), .dout_valid(dout_valid1), .dout_ready(dout_ready1),
    .dout_last(dout_last1), .busy(busy1), .frame_done(frame_done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Bit-serial reference: flatten pairs (din[1] first), append two zero tail
  // bits, run the 7/5 code over the bit stream and regroup into 4-bit words.
  task automatic ref_words(input logic [1:0] pairs[$], output logic [3:0] words[$]);
    logic       bits[$];
    logic [1:0] cp[$];
    logic       b, b1, b2;
    words = {};
    foreach (pairs[i]) begin
      bits.push_back(pairs[i][1]);
      bits.push_back(pairs[i][0]);
    end
    bits.push_back(1'b0);
    bits.push_back(1'b0);
    for (int i = 0; i < bits.size(); i++) begin
      b  = bits[i];
      b1 = (i >= 1) ? bits[i-1] : 1'b0;
      b2 = (i >= 2) ? bits[i-2] : 1'b0;
      cp.push_back({b ^ b1 ^ b2, b ^ b2});
    end
    for (int j = 0; j < cp.size() / 2; j++) words.push_back({cp[2*j], cp[2*j+1]});
  endtask

  task automatic run_frame(input bit full_rate, input int stall_at, input int gap_at,
                           input bit poke, input int first_pair, input int abort_at);
    logic [1:0] src[FP];
    logic [1:0] sent[$];
    logic [3:0] got[$];
    logic       lastg[$];
    logic [3:0] expw[$];
    int         acc = 0;
    int         cyc = 0;
    bit         done_prev = 0, fin = 0, aborted = 0;
    logic [3:0] p_dout = '0;
    logic       p_valid = 0, p_cons = 0, p_acc = 0, p_last = 0;
    for (int i = 0; i < FP; i++) src[i] = 2'($urandom_range(0, 3));
    if (first_pair >= 0) src[0] = 2'(first_pair);
    while (!fin) begin
      @(negedge clk);
      en         = !(gap_at >= 0 && cyc >= gap_at && cyc < gap_at + 3);
      dout_ready = (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 5) ? 1'b0 :
                   (full_rate ? 1'b1 : ($urandom_range(0, 3) != 0));
      din_valid  = done_prev ? 1'b0 : (full_rate ? 1'b1 : ($urandom_range(0, 4) != 0));
      din        = (acc < FP) ? src[acc] : 2'($urandom_range(0, 3));
      start      = (cyc == 0) ? 1'b1 :
                   (done_prev ? 1'b0 : (poke ? ((acc >= FP) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0));
      #1;
      chk("din_ready", din_ready, en && cyc >= 1 && acc < FP && (!dout_valid || dout_ready));
      chk("busy", busy, cyc >= 1 && !done_prev);
      chk("frame_done", frame_done, done_prev && en);
      if (cyc > 0 && p_acc) chk("lat_valid", dout_valid, 1);
      if (cyc > 0 && p_valid && !p_cons) begin
        chk("hold_dout", dout, p_dout);
        chk("hold_valid", dout_valid, 1);
        chk("hold_last", dout_last, p_last);
      end
      if (done_prev) begin
        fin = 1;
      end else if (abort_at >= 0 && acc == abort_at) begin
        rst = 1'b0;
        #1;
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_last", dout_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_ready", din_ready, 0);
        aborted = 1;
        fin = 1;
      end else begin
        p_acc = din_valid && din_ready;
        if (p_acc) begin
          sent.push_back(din);
          acc++;
        end
        p_cons = en && dout_valid && dout_ready;
        if (p_cons) begin
          got.push_back(dout);
          lastg.push_back(dout_last);
          if (dout_last) done_prev = 1;
        end
        p_dout  = dout;
        p_valid = dout_valid;
        p_last  = dout_last;
        cyc++;
        if (cyc > 400) begin
          chk("timeout", 0, 1);
          fin = 1;
        end
      end
    end
    if (!aborted) begin
      ref_words(sent, expw);
      chk("pairs_accepted", acc, FP);
      chk("words_out", got.size(), FP + 1);
      for (int i = 0; i < got.size() && i < expw.size(); i++) begin
        chk($sformatf("word%0d", i), got[i], expw[i]);
        chk($sformatf("last%0d", i), lastg[i], (i == FP));
      end
      if (first_pair == 3 && got.size() > 0) chk("first_word_11", got[0], 4'b1101);
      start     = 1'b0;
      din_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
        @(negedge clk);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_ready", din_ready, 0);
      end
      din_valid = 1'b0;
    end
  endtask

  initial begin
    #12;
    chk("reset_dout", dout, 0);
    chk("reset_valid", dout_valid, 0);
    chk("reset_last", dout_last, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", frame_done, 0);
    chk("reset_ready", din_ready, 0);
    @(negedge clk);
    rst = 1'b1;

    // Single-pair frame on the FRAME_PAIRS=1 instance.
    en1 = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; din1 = 2'b11; din_valid1 = 1'b1; dout_ready1 = 1'b1;
    #1;
    chk("d1_busy", busy1, 1);
    chk("d1_ready", din_ready1, 1);
    @(negedge clk);
    din_valid1 = 1'b0;
    #1;
    chk("d1_word", dout1, 4'b1101);
    chk("d1_valid", dout_valid1, 1);
    chk("d1_notlast", dout_last1, 0);
    @(negedge clk);
    #1;
    chk("d1_tail", dout1, 4'b0111);
    chk("d1_last", dout_last1, 1);
    chk("d1_tail_valid", dout_valid1, 1);
    @(negedge clk);
    #1;
    chk("d1_done", frame_done1, 1);
    chk("d1_busy_off", busy1, 0);
    chk("d1_valid_off", dout_valid1, 0);
    @(negedge clk);
    #1;
    chk("d1_done_pulse", frame_done1, 0);

    run_frame(0, -1, -1, 0, -1, -1);
    run_frame(1, -1, -1, 0, -1, -1);
    run_frame(1, 4, -1, 0, -1, -1);
    run_frame(0, -1, 5, 0, -1, -1);
    run_frame(1, 3, 5, 0, -1, -1);
    run_frame(0, -1, -1, 1, -1, -1);
    run_frame(1, -1, -1, 1, -1, -1);
    run_frame(1, -1, -1, 0, -1, 3);
    @(negedge clk);
    rst = 1'b1;
    run_frame(1, -1, -1, 0, 3, -1);
    for (int k = 0; k < 6; k++) begin
      run_frame(1'($urandom_range(0, 1)), $urandom_range(0, 1) ? int'($urandom_range(2, 8)) : -1,
                $urandom_range(0, 1) ? int'($urandom_range(2, 8)) : -1, 1'($urandom_range(0, 1)), -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
